// File: rtl/multi_cursor_renderer_pkg.sv
// Shared colour constants, renderer state encoding and width helpers
// used by the overlay renderers and their sprite ROMs.
package multi_cursor_renderer_pkg;

  // RGB332 colour entries; all-zero means "transparent, no overlay".
  localparam int COLOR_WIDTH = 8;
  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 8'h00;
  localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 8'hE0;
  localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 8'h1C;
  localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 8'h03;
  localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 8'hFF;

  // Common state set for sprite/overlay renderer FSMs.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ERASE = 2'd2,
    ST_DRAW  = 2'd3
  } render_state_e;

  // $clog2 that never returns zero, so single-entry dimensions still get a 1-bit counter.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/cursor_sprite_rom.sv
// Combinational sprite mask lookup: returns whether pixel (row, col) of the
// cursor sprite is opaque. SHAPE 0 is a solid square, SHAPE 1 an arrow
// (lower-left triangle including the diagonal).
module cursor_sprite_rom
  import multi_cursor_renderer_pkg::*;
#(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int SHAPE    = 1
) (
  input  logic [clog2_min1(SPRITE_H)-1:0] row_i,
  input  logic [clog2_min1(SPRITE_W)-1:0] col_i,
  output logic                            mask_o
);

  // Mask bit from the selected shape; both coordinates are compared at 32 bits.
  always_comb begin
    mask_o = (SHAPE == 0) || (32'(col_i) <= 32'(row_i));
  end

endmodule

// File: rtl/multi_cursor_renderer.sv
// Overlay frame renderer for several cursors. Keeps a WIDTHxHEIGHT colour
// frame in inferred RAM, clears it after reset, and on any cursor change
// erases stale sprites and redraws all enabled ones, one pixel per cycle.
// The compositor reads the overlay through a registered read port.
module multi_cursor_renderer
  import multi_cursor_renderer_pkg::*;
#(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int NUM_CURSORS = 2,
  parameter int SPRITE_W    = 8,
  parameter int SPRITE_H    = 8,
  parameter int SHAPE       = 1,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CURSORS-1:0]             cursor_en,
  input  logic [NUM_CURSORS*XW-1:0]          cursor_x,
  input  logic [NUM_CURSORS*YW-1:0]          cursor_y,
  input  logic [NUM_CURSORS*COLOR_WIDTH-1:0] cursor_color,
  input  logic [XW-1:0]                      request_x,
  input  logic [YW-1:0]                      request_y,
  output logic [COLOR_WIDTH-1:0]             render_color,
  output logic                               busy,
  output logic                               pass_done
);

  localparam int N     = NUM_CURSORS;
  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = clog2_min1(DEPTH);
  localparam int CIW   = clog2_min1(N);
  localparam int RW    = clog2_min1(SPRITE_H);
  localparam int CLW   = clog2_min1(SPRITE_W);
  localparam logic [XW:0] X_LIMIT = (XW+1)'(WIDTH);
  localparam logic [YW:0] Y_LIMIT = (YW+1)'(HEIGHT);

  typedef logic [COLOR_WIDTH-1:0] color_t;

  // Unpacked views of the packed cursor inputs.
  logic [XW-1:0] in_x [N];
  logic [YW-1:0] in_y [N];
  color_t        in_c [N];

  // Snapshot taken when a pass starts, and record of what is on screen.
  logic [N-1:0]  snap_en_q;
  logic [XW-1:0] snap_x_q [N];
  logic [YW-1:0] snap_y_q [N];
  color_t        snap_c_q [N];
  logic [N-1:0]  drawn_valid_q;
  logic [XW-1:0] drawn_x_q [N];
  logic [YW-1:0] drawn_y_q [N];
  color_t        drawn_c_q [N];

  logic [N-1:0] dirty;
  logic [N-1:0] erase_in;   // erase candidates judged against live inputs (IDLE)
  logic [N-1:0] erase_sn;   // erase candidates judged against the snapshot (ERASE)

  render_state_e   state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic [CIW-1:0]  cur_q, cur_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CLW-1:0]  col_q, col_d;
  logic            pass_done_q, pass_done_d;
  logic            snap_load, rec_update;

  logic            mask_bit;
  logic            last_pix;
  logic [CIW:0]    erase_first_in, draw_first_in, erase_nxt, draw_first, draw_nxt;

  logic [XW-1:0]   base_x;
  logic [YW-1:0]   base_y;
  logic [XW:0]     px;
  logic [YW:0]     py;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  color_t          wr_data;

  logic            rd_in_range;
  logic [AW-1:0]   rd_addr;
  color_t          render_color_q;

  color_t          frame_mem [DEPTH];

  for (genvar gi = 0; gi < N; gi++) begin : g_cursor
    assign in_x[gi] = cursor_x[gi*XW +: XW];
    assign in_y[gi] = cursor_y[gi*YW +: YW];
    assign in_c[gi] = cursor_color[gi*COLOR_WIDTH +: COLOR_WIDTH];

    // A colour-only change redraws in place, so it is dirty but not erased.
    assign dirty[gi] = (cursor_en[gi] != drawn_valid_q[gi]) ||
                       (cursor_en[gi] && ((in_x[gi] != drawn_x_q[gi]) ||
                                          (in_y[gi] != drawn_y_q[gi]) ||
                                          (in_c[gi] != drawn_c_q[gi])));
    assign erase_in[gi] = drawn_valid_q[gi] &&
                          (!cursor_en[gi] || (in_x[gi] != drawn_x_q[gi]) ||
                                             (in_y[gi] != drawn_y_q[gi]));
    assign erase_sn[gi] = drawn_valid_q[gi] &&
                          (!snap_en_q[gi] || (snap_x_q[gi] != drawn_x_q[gi]) ||
                                             (snap_y_q[gi] != drawn_y_q[gi]));
  end

  // Lowest set index >= start; returns {found, index}.
  function automatic logic [CIW:0] find_from(input logic [N-1:0] mask, input int start);
    logic [CIW:0] r;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[k] && (k >= start)) r = {1'b1, CIW'(k)};
    end
    return r;
  endfunction

  cursor_sprite_rom #(
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H),
    .SHAPE   (SHAPE)
  ) u_sprite_rom (
    .row_i (row_q),
    .col_i (col_q),
    .mask_o(mask_bit)
  );

  // Cursor selection helpers for the start of a pass and the next sprite.
  always_comb begin
    erase_first_in = find_from(erase_in, 0);
    draw_first_in  = find_from(cursor_en, 0);
    erase_nxt      = find_from(erase_sn, int'(cur_q) + 1);
    draw_first     = find_from(snap_en_q, 0);
    draw_nxt       = find_from(snap_en_q, int'(cur_q) + 1);
    last_pix       = (row_q == RW'(SPRITE_H - 1)) && (col_q == CLW'(SPRITE_W - 1));
  end

  // Next-state logic: clear sweep, dirty detection, sprite walk and cursor sequencing.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    cur_d       = cur_q;
    row_d       = row_q;
    col_d       = col_q;
    pass_done_d = 1'b0;
    snap_load   = 1'b0;
    rec_update  = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        if (clr_addr_q == AW'(DEPTH - 1)) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (|dirty) begin
          snap_load = 1'b1;
          row_d     = '0;
          col_d     = '0;
          // A dirty cursor either needs erasing or is enabled, so one branch always hits.
          if (erase_first_in[CIW]) begin
            state_d = ST_ERASE;
            cur_d   = erase_first_in[CIW-1:0];
          end else begin
            state_d = ST_DRAW;
            cur_d   = draw_first_in[CIW-1:0];
          end
        end
      end
      ST_ERASE, ST_DRAW: begin
        if (last_pix) begin
          row_d = '0;
          col_d = '0;
          if ((state_q == ST_ERASE) && erase_nxt[CIW]) begin
            cur_d = erase_nxt[CIW-1:0];
          end else if ((state_q == ST_ERASE) && draw_first[CIW]) begin
            state_d = ST_DRAW;
            cur_d   = draw_first[CIW-1:0];
          end else if ((state_q == ST_DRAW) && draw_nxt[CIW]) begin
            cur_d = draw_nxt[CIW-1:0];
          end else begin
            state_d     = ST_IDLE;
            pass_done_d = 1'b1;
            rec_update  = 1'b1;
          end
        end else if (col_q == CLW'(SPRITE_W - 1)) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Frame write port: clear sweep or the current masked, clipped sprite pixel.
  always_comb begin
    base_x  = (state_q == ST_ERASE) ? drawn_x_q[cur_q] : snap_x_q[cur_q];
    base_y  = (state_q == ST_ERASE) ? drawn_y_q[cur_q] : snap_y_q[cur_q];
    px      = {1'b0, base_x} + (XW+1)'(col_q);
    py      = {1'b0, base_y} + (YW+1)'(row_q);
    wr_en   = 1'b0;
    wr_addr = clr_addr_q;
    wr_data = COLOR_NONE;
    if (state_q == ST_CLEAR) begin
      wr_en = 1'b1;
    end else if ((state_q == ST_ERASE) || (state_q == ST_DRAW)) begin
      wr_en   = mask_bit && (px < X_LIMIT) && (py < Y_LIMIT);
      wr_addr = AW'(py) * AW'(WIDTH) + AW'(px);
      wr_data = (state_q == ST_DRAW) ? snap_c_q[cur_q] : COLOR_NONE;
    end
  end

  // FSM and sprite-walk registers; reset always restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      cur_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      cur_q       <= cur_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pass_done_q <= pass_done_d;
    end
  end

  // Snapshot inputs at pass start; commit the on-screen record at pass end.
  always_ff @(posedge clk) begin
    if (reset) begin
      drawn_valid_q <= '0;
    end else begin
      if (snap_load) begin
        snap_en_q <= cursor_en;
        for (int k = 0; k < N; k++) begin
          snap_x_q[k] <= in_x[k];
          snap_y_q[k] <= in_y[k];
          snap_c_q[k] <= in_c[k];
        end
      end
      if (rec_update) begin
        drawn_valid_q <= snap_en_q;
        for (int k = 0; k < N; k++) begin
          if (snap_en_q[k]) begin
            drawn_x_q[k] <= snap_x_q[k];
            drawn_y_q[k] <= snap_y_q[k];
            drawn_c_q[k] <= snap_c_q[k];
          end
        end
      end
    end
  end

  // Frame RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en) frame_mem[wr_addr] <= wr_data;
  end

  assign rd_in_range = ({1'b0, request_x} < X_LIMIT) && ({1'b0, request_y} < Y_LIMIT);
  assign rd_addr     = AW'(request_y) * AW'(WIDTH) + AW'(request_x);

  // Registered read port; a same-cycle write to the address returns the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      render_color_q <= COLOR_NONE;
    end else if (rd_in_range) begin
      render_color_q <= frame_mem[rd_addr];
    end else begin
      render_color_q <= COLOR_NONE;
    end
  end

  assign render_color = render_color_q;
  assign busy         = (state_q != ST_IDLE);
  assign pass_done    = pass_done_q;

endmodule
